morse_playback: RTL and testbench
=================================

// Module: morse_playback
// PURPOSE
//  Reads the 30-bit letter store from sequence_storage and plays it out as a timed
//  on/off Morse signal on morse_out, which drives an LED or buzzer.
//  Letters play in order [29:20], [19:10], [9:0]. Each letter is 5 two-bit symbols,
//  MSB pair first: 00 = dot, 01 = dash, 11 = end of letter, 10 = reserved (treated as end).
// PARAMETERS
//  UNIT_CYCLES  25_000_000  clock cycles per Morse time unit (>=2)
//  CNT_W        $clog2(3*UNIT_CYCLES+1)  width of the internal duration counter
// PORTS
//  clk          in   1   system clock; all logic is on its rising edge
//  reset        in   1   synchronous, active-high reset
//  store_seqs   in   30  letter store {L0[29:20], L1[19:10], L2[9:0]}
//  storageSent  in   1   level from storage, high after enter; a 0->1 transition starts playback
//  morse_out    out  1   keyed Morse signal, 1 = mark
//  busy         out  1   high while playback is in progress
//  done         out  1   one-cycle pulse when playback completes
//  letter_idx   out  2   index of the letter being played (0..2); 0 when idle
// BEHAVIOUR
//  Reset: morse_out=0, busy=0, done=0, letter_idx=0, state=IDLE, counter=0.
//   The sent_prev edge register resets to 1, so a start needs a true 0->1 edge after reset.
//   Reset applied mid-playback takes effect on the next edge with the same values; playback is abandoned.
//  FSM states: IDLE -> FETCH -> MARK -> GAP -> (FETCH | LGAP | TAIL) ... -> IDLE.
//  Start: in cycle T, IDLE samples storageSent=1 with sent_prev=0.
//   At edge T+1: store_seqs is latched into a shadow register, busy=1, state=FETCH.
//   The store may change afterwards without affecting playback.
//   Edges that arrive while busy are consumed (sent_prev still updates) and ignored.
//  Timing, with U=UNIT_CYCLES; all durations are exact counts of morse_out cycles:
//   dot = U cycles high; dash = 3U high.
//   Gap between marks of the same letter = U low.
//   Gap between letters = 3U low.
//   Trailing gap after the final mark = 3U low.
//   The first mark rises at edge T+2. FETCH/decision cycles are absorbed into gaps and never lengthen them.
//  Letter end: a letter ends at its first 11/10 symbol, or after 5 marks.
//   A letter whose first symbol is 11/10 is empty: it is skipped with no gap and no letter_idx dwell.
//   The inter-letter gap is inserted only if a later non-empty letter exists; otherwise TAIL runs.
//  Completion: on the cycle after TAIL ends, done=1 for exactly one cycle, busy=0, state=IDLE.
//   A new start edge may be accepted in that same done cycle.
//  All-empty store (30'h3FFFFFFF): morse_out never asserts.
//   done pulses exactly once within 8 cycles of T, with no trailing gap.
//  letter_idx changes at the first cycle of each letter's first mark.
//  morse_out is driven directly from a register (glitch-free).
// TESTING (bench overrides UNIT_CYCLES=4)
//  Reset, then storageSent held high continuously -> no playback: morse_out=0, busy=0, done never pulses.
//  SOS store {0000001111,0101011111,0000001111}, rising edge sampled in cycle T ->
//   busy=1 over T+1..T+121.
//   morse_out high over [T+2,+4), [T+10,+4), [T+18,+4), [T+34,+12), [T+50,+12),
//   [T+66,+12), [T+90,+4), [T+98,+4), [T+106,+4]; low in all other cycles.
//   done=1 only in cycle T+122.
//  Store {1111111111,0101011111,1111111111} ("O" only) ->
//   three 12-cycle marks separated by 4-cycle gaps, then 12 cycles low, then done.
//   letter_idx=1 throughout.
//  Store 30'h3FFFFFFF -> morse_out stays 0; done pulses exactly once.
//  storageSent toggled 1->0->1 during SOS playback -> ignored; the waveform is identical to the SOS case.
//  Reset asserted at T+40 -> at edge T+41: morse_out=0, busy=0.
//   No done pulse follows; a new edge restarts playback from letter 0.

Source files
------------

// File: rtl/morse_playback.sv
// Plays a latched three-letter Morse store out as a timed on/off signal on morse_out.
// Letters play L0, L1, L2; each letter is up to five 2-bit symbols (00 dot, 01 dash, 1x end).
module morse_playback #(
    parameter int UNIT_CYCLES = 25_000_000,
    parameter int CNT_W       = $clog2(3 * UNIT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] store_seqs,
    input  logic        storageSent,
    output logic        morse_out,
    output logic        busy,
    output logic        done,
    output logic [1:0]  letter_idx
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MARK,
        GAP,
        LGAP,
        TAIL
    } state_t;

    localparam logic [CNT_W-1:0] UNIT_LAST   = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIPLE_LAST = CNT_W'(3 * UNIT_CYCLES - 1);

    state_t           state;
    logic [29:0]      shadow;
    logic [1:0]       cur_letter;
    logic [2:0]       cur_sym;
    logic [CNT_W-1:0] count;
    logic             sent_prev;

    logic       in_letter;
    logic       found;
    logic [1:0] cand;
    logic       cand_dash;
    logic       cur_dash;
    logic [1:0] sym_next;
    logic [1:0] lead_sym;
    logic [1:0] cand_sym;
    logic [1:0] cur_s;

    function automatic logic [1:0] sym_at(input logic [29:0] st, input logic [1:0] l,
                                          input logic [2:0] s);
        logic [9:0] letter;
        logic [1:0] sym;
        case (l)
            2'd0:    letter = st[29:20];
            2'd1:    letter = st[19:10];
            default: letter = st[9:0];
        endcase
        case (s)
            3'd0:    sym = letter[9:8];
            3'd1:    sym = letter[7:6];
            3'd2:    sym = letter[5:4];
            3'd3:    sym = letter[3:2];
            3'd4:    sym = letter[1:0];
            default: sym = 2'b11;
        endcase
        return sym;
    endfunction

    // Lookahead: decides at the end of each mark (or in FETCH) where the next mark lives,
    // so the decision never costs an extra cycle inside a gap.
    always_comb begin
        sym_next  = sym_at(shadow, cur_letter, cur_sym + 3'd1);
        in_letter = (cur_sym < 3'd4) && !sym_next[1];
        found     = 1'b0;
        cand      = '0;
        lead_sym  = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            lead_sym = sym_at(shadow, 2'(i), 3'd0);
            if (!found && ((state == FETCH) || (2'(i) > cur_letter)) && !lead_sym[1]) begin
                found = 1'b1;
                cand  = 2'(i);
            end
        end
        cand_sym  = sym_at(shadow, cand, 3'd0);
        cand_dash = cand_sym[0];
        cur_s     = sym_at(shadow, cur_letter, cur_sym);
        cur_dash  = cur_s[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shadow     <= '0;
            cur_letter <= '0;
            cur_sym    <= '0;
            count      <= '0;
            sent_prev  <= 1'b1;
            morse_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            letter_idx <= '0;
        end else begin
            sent_prev <= storageSent;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (storageSent && !sent_prev) begin
                        shadow <= store_seqs;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (found) begin
                        cur_letter <= cand;
                        cur_sym    <= '0;
                        letter_idx <= cand;
                        morse_out  <= 1'b1;
                        count      <= cand_dash ? TRIPLE_LAST : UNIT_LAST;
                        state      <= MARK;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                MARK: begin
                    if (count == '0) begin
                        morse_out <= 1'b0;
                        if (in_letter) begin
                            cur_sym <= cur_sym + 3'd1;
                            count   <= UNIT_LAST;
                            state   <= GAP;
                        end else if (found) begin
                            cur_letter <= cand;
                            cur_sym    <= '0;
                            count      <= TRIPLE_LAST;
                            state      <= LGAP;
                        end else begin
                            count <= TRIPLE_LAST;
                            state <= TAIL;
                        end
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                GAP, LGAP: begin
                    if (count == '0) begin
                        morse_out  <= 1'b1;
                        letter_idx <= cur_letter;
                        count      <= cur_dash ? TRIPLE_LAST : UNIT_LAST;
                        state      <= MARK;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                TAIL: begin
                    if (count == '0) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        letter_idx <= '0;
                        state      <= IDLE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_playback.sv
// Scoreboard bench for morse_playback: stimulus queues expected mark/done/busy events,
// a negedge monitor turns DUT output transitions into events and checks them in order.
module tb_morse_playback;

    localparam int U = 4;
    localparam logic [29:0] SOS   = 30'b0000001111_0101011111_0000001111;
    localparam logic [29:0] O_ONLY = 30'b1111111111_0101011111_1111111111;
    localparam logic [29:0] EMPTY = 30'h3FFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        storageSent;
    logic [29:0] store_seqs;
    logic        morse_out;
    logic        busy;
    logic        done;
    logic [1:0]  letter_idx;

    always #5 clk = ~clk;

    morse_playback #(.UNIT_CYCLES(U)) dut (
        .clk        (clk),
        .reset      (reset),
        .store_seqs (store_seqs),
        .storageSent(storageSent),
        .morse_out  (morse_out),
        .busy       (busy),
        .done       (done),
        .letter_idx (letter_idx)
    );

    typedef enum int {EV_MARK = 0, EV_DONE = 1, EV_BUSY = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       c_lo;
        int       c_hi;
        int       len;
        int       idx;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  track_busy = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_t k, input int lo, input int hi, input int len, input int idx);
        ev_t e;
        e.kind = k;
        e.c_lo = lo;
        e.c_hi = hi;
        e.len  = len;
        e.idx  = idx;
        q.push_back(e);
    endtask

    task automatic consume(input ev_kind_t k, input int c, input int len, input int idx);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event kind=%0d cycle=%0d actual=present required=none",
                     int'(k), c);
        end else begin
            e = q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            checks++;
            if (c < e.c_lo || c > e.c_hi) begin
                failures++;
                $display("FAIL event_cycle kind=%0d actual=%0d required=%0d..%0d",
                         int'(k), c, e.c_lo, e.c_hi);
            end
            if (e.kind == EV_MARK || e.kind == EV_BUSY) check("event_len", len, e.len);
            if (e.kind == EV_MARK) check("mark_letter_idx", idx, e.idx);
        end
    endtask

    logic p_mo = 1'b0;
    logic p_busy = 1'b0;
    int   mark_start = 0;
    int   mark_idx = 0;
    int   busy_start = 0;

    always @(negedge clk) begin
        if (morse_out === 1'b1 && p_mo == 1'b0) begin
            mark_start = cyc;
            mark_idx   = int'(letter_idx);
        end
        if (morse_out !== 1'b1 && p_mo == 1'b1) consume(EV_MARK, mark_start, cyc - mark_start, mark_idx);
        if (done === 1'b1) consume(EV_DONE, cyc, 0, 0);
        if (busy === 1'b1 && p_busy == 1'b0) busy_start = cyc;
        if (busy !== 1'b1 && p_busy == 1'b1 && track_busy)
            consume(EV_BUSY, busy_start, cyc - busy_start, 0);
        p_mo   = (morse_out === 1'b1);
        p_busy = (busy === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Produces a clean 0->1 edge; returns T, the cycle in which the DUT samples the 1.
    task automatic start(input logic [29:0] st, output int t);
        store_seqs  = st;
        storageSent = 1'b0;
        tick(1);
        storageSent = 1'b1;
        t = cyc;
    endtask

    task automatic push_sos(input int t);
        int st[9]  = '{2, 10, 18, 34, 50, 66, 90, 98, 106};
        int ln[9]  = '{4, 4, 4, 12, 12, 12, 4, 4, 4};
        int ix[9]  = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        for (int i = 0; i < 9; i++) push(EV_MARK, t + st[i], t + st[i], ln[i], ix[i]);
        push(EV_DONE, t + 122, t + 122, 0, 0);
        push(EV_BUSY, t + 1, t + 1, 121, 0);
    endtask

    initial begin
        int t;
        reset       = 1'b1;
        storageSent = 1'b1;
        store_seqs  = SOS;
        tick(3);
        check("reset_morse_out", int'(morse_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_letter_idx", int'(letter_idx), 0);
        reset = 1'b0;

        // storageSent held high across reset: no edge, so nothing plays
        tick(30);
        check("held_busy", int'(busy), 0);
        check("held_morse_out", int'(morse_out), 0);
        check("held_pending", q.size(), 0);

        // SOS; store changed after latch must not matter
        start(SOS, t);
        push_sos(t);
        tick(2);
        store_seqs = O_ONLY;
        tick(130);
        check("sos_pending", q.size(), 0);

        // "O" only in the middle letter
        start(O_ONLY, t);
        push(EV_MARK, t + 2, t + 2, 12, 1);
        push(EV_MARK, t + 18, t + 18, 12, 1);
        push(EV_MARK, t + 34, t + 34, 12, 1);
        push(EV_DONE, t + 58, t + 58, 0, 0);
        push(EV_BUSY, t + 1, t + 1, 57, 0);
        tick(70);
        check("o_pending", q.size(), 0);

        // All-empty store: a single done within 8 cycles, no marks
        track_busy = 1'b0;
        start(EMPTY, t);
        push(EV_DONE, t + 1, t + 8, 0, 0);
        tick(20);
        check("empty_pending", q.size(), 0);
        check("empty_busy", int'(busy), 0);
        track_busy = 1'b1;

        // Edge toggled during playback is ignored
        start(SOS, t);
        push_sos(t);
        tick(20);
        storageSent = 1'b0;
        tick(5);
        storageSent = 1'b1;
        tick(110);
        check("toggle_pending", q.size(), 0);

        // Reset in cycle T+40 abandons playback; a fresh edge restarts from letter 0
        start(SOS, t);
        push(EV_MARK, t + 2, t + 2, 4, 0);
        push(EV_MARK, t + 10, t + 10, 4, 0);
        push(EV_MARK, t + 18, t + 18, 4, 0);
        push(EV_MARK, t + 34, t + 34, 7, 1);
        push(EV_BUSY, t + 1, t + 1, 40, 0);
        tick(40);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midreset_morse_out", int'(morse_out), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_letter_idx", int'(letter_idx), 0);
        tick(20);
        check("midreset_pending", q.size(), 0);
        start(SOS, t);
        push_sos(t);
        tick(130);
        check("restart_pending", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
